// File: rtl/tanh_divider.sv
// tanh_divider: computes tanhx = sinhx / coshx with a restoring divider that
// produces one quotient bit per clock. The result is saturated to +/-1.0 and
// the sign of sinhx is applied afterwards.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   sinhx      signed dividend, sampled only on accept
//   coshx      divisor, unsigned magnitude, sampled only on accept
//   in_valid   level valid; only a rising edge starts an operation
//   tanhx      signed result, held until the next result
//   out_valid  one-cycle pulse when tanhx updates
//   busy       high from accept through the out_valid cycle
//   div_err    high with out_valid when coshx was zero
//   overrun    sticky flag: a start edge arrived while busy
module tanh_divider #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sinhx,
  input  logic [WIDTH-1:0] coshx,
  input  logic             in_valid,
  output logic [WIDTH-1:0] tanhx,
  output logic             out_valid,
  output logic             busy,
  output logic             div_err,
  output logic             overrun
);

  localparam int unsigned ITER = WIDTH + FRAC;
  localparam int unsigned CW   = $clog2(ITER + 1);
  localparam logic [ITER-1:0]  ONE_Q = ITER'(1) << FRAC;
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1) << FRAC;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_e;

  state_e           state_q, state_d;
  logic             vld_prev_q;
  logic             sign_q, sign_d;
  logic [ITER-1:0]  d_q, d_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [ITER-1:0]  q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] tanhx_q, tanhx_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             div_err_q, div_err_d;
  logic             overrun_q, overrun_d;

  logic             start, accept, ge;
  logic [WIDTH-1:0] abs_in, mag;
  logic [WIDTH:0]   r_shift, r_sub;

  // busy_q is still high in the out_valid cycle (state already IDLE), which
  // keeps a start edge in that cycle from being accepted.
  assign start  = in_valid & ~vld_prev_q;
  assign accept = start && (state_q == S_IDLE) && !busy_q;

  assign abs_in  = sinhx[WIDTH-1] ? -sinhx : sinhx;
  assign r_shift = {r_q, d_q[ITER-1]};
  assign r_sub   = r_shift - {1'b0, c_q};
  // No borrow out of the subtraction means r_shift >= C.
  assign ge      = ~r_sub[WIDTH];
  assign mag     = (q_q > ONE_Q) ? ONE_W : q_q[WIDTH-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_DIV;
      S_DIV:  if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    sign_d      = sign_q;
    d_d         = d_q;
    c_d         = c_q;
    r_d         = r_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    tanhx_d     = tanhx_q;
    out_valid_d = 1'b0;
    busy_d      = out_valid_q ? 1'b0 : busy_q;
    div_err_d   = out_valid_q ? 1'b0 : div_err_q;
    overrun_d   = overrun_q | (start & ~accept);
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          sign_d = sinhx[WIDTH-1];
          d_d    = {abs_in, {FRAC{1'b0}}};
          c_d    = coshx;
          r_d    = '0;
          q_d    = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
        end
      end
      S_DIV: begin
        r_d   = ge ? r_sub[WIDTH-1:0] : r_shift[WIDTH-1:0];
        d_d   = d_q << 1;
        q_d   = {q_q[ITER-2:0], ge};
        cnt_d = cnt_q + CW'(1);
      end
      S_FIX: begin
        out_valid_d = 1'b1;
        if (c_q == '0) begin
          tanhx_d   = '0;
          div_err_d = 1'b1;
        end else begin
          tanhx_d   = sign_q ? -mag : mag;
          div_err_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_prev_q  <= 1'b0;
      sign_q      <= 1'b0;
      d_q         <= '0;
      c_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      tanhx_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      div_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      vld_prev_q  <= in_valid;
      sign_q      <= sign_d;
      d_q         <= d_d;
      c_q         <= c_d;
      r_q         <= r_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      tanhx_q     <= tanhx_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      div_err_q   <= div_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign tanhx     = tanhx_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign div_err   = div_err_q;
  assign overrun   = overrun_q;

endmodule
